// File: rtl/poly_stream_io.sv
// Host-side streaming port for the polynomial RAM: loads coefficients from a
// valid/ready input stream and streams them back out through a 2-entry FIFO.
module poly_stream_io #(
    parameter int N      = 512,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16,
    parameter int Q      = 12289
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              unload_start,
    output logic              busy,
    output logic              done,
    output logic              range_err,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              ram_wea,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [DATA_W-1:0] ram_dia,
    input  logic [DATA_W-1:0] ram_doa
);

    typedef enum logic [1:0] {IDLE, LOAD, UNLOAD} state_t;

    localparam logic [ADDR_W:0]   LAST   = (ADDR_W+1)'(N - 1);
    localparam logic [ADDR_W:0]   NCOEF  = (ADDR_W+1)'(N);
    localparam logic [DATA_W-1:0] Q_DATA = DATA_W'(Q);

    state_t            state;
    logic [ADDR_W:0]   ld_cnt;
    logic [ADDR_W:0]   rd_cnt;
    logic [ADDR_W:0]   out_cnt;
    logic              rd_vld_p1;
    logic [DATA_W-1:0] fifo_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        fifo_count;
    logic [2:0]        occupancy;
    logic              hs;
    logic              pop;
    logic              rd_issue;

    assign busy    = (state != IDLE);
    assign s_ready = (state == LOAD);
    assign hs      = s_ready & s_valid;
    assign m_valid = (fifo_count != 2'd0);
    assign pop     = m_valid & m_ready;
    assign m_data  = m_valid ? fifo_mem[rd_ptr] : '0;

    // A read may be issued only if the FIFO can absorb it once the read in
    // flight lands, counting the slot freed by this cycle's pop.
    assign occupancy = {1'b0, fifo_count} + {2'b00, rd_vld_p1};
    assign rd_issue  = (state == UNLOAD) && (rd_cnt < NCOEF) &&
                       (occupancy < (3'd2 + {2'b00, pop}));

    assign ram_wea   = hs;
    assign ram_dia   = (state == LOAD) ? s_data : '0;
    assign ram_addra = (state == LOAD)   ? ld_cnt[ADDR_W-1:0] :
                       (state == UNLOAD) ? rd_cnt[ADDR_W-1:0] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ld_cnt     <= '0;
            rd_cnt     <= '0;
            out_cnt    <= '0;
            rd_vld_p1  <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
            done       <= 1'b0;
            range_err  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load_start) begin
                        state     <= LOAD;
                        ld_cnt    <= '0;
                        range_err <= 1'b0;
                    end else if (unload_start) begin
                        state      <= UNLOAD;
                        rd_cnt     <= '0;
                        out_cnt    <= '0;
                        rd_vld_p1  <= 1'b0;
                        wr_ptr     <= 1'b0;
                        rd_ptr     <= 1'b0;
                        fifo_count <= 2'd0;
                    end
                end
                LOAD: begin
                    if (hs) begin
                        ld_cnt <= ld_cnt + 1'b1;
                        if (s_data >= Q_DATA) range_err <= 1'b1;
                        if (ld_cnt == LAST) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                UNLOAD: begin
                    rd_vld_p1  <= rd_issue;
                    fifo_count <= fifo_count + {1'b0, rd_vld_p1} - {1'b0, pop};
                    if (rd_issue)  rd_cnt <= rd_cnt + 1'b1;
                    if (rd_vld_p1) wr_ptr <= ~wr_ptr;
                    if (pop) begin
                        rd_ptr  <= ~rd_ptr;
                        out_cnt <= out_cnt + 1'b1;
                        if (out_cnt == LAST) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // p1 stage: RAM read data lands in the FIFO one cycle after its address.
    always_ff @(posedge clk) begin
        if (state == UNLOAD && rd_vld_p1) fifo_mem[wr_ptr] <= ram_doa;
    end

endmodule

// File: doc/poly_stream_io.md
# poly_stream_io

Host-side streaming port for the 512-coefficient polynomial RAM. It loads a polynomial into RAM from a valid/ready input stream before an NTT or inverse NTT runs, and it streams the polynomial back out over a valid/ready output stream after the transform completes. It is the consumer/producer counterpart of the NTT engine on the same dual-port RAM. It owns RAM port A only while `busy` is high; top-level muxing gives port A to the NTT engine otherwise.

## Interface
- `N`, 512: coefficients per polynomial.
- `ADDR_W`, 9: RAM address width (log2 N).
- `DATA_W`, 16: coefficient width.
- `Q`, 12289: modulus used for the range check.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `load_start` input 1: request a load; sampled only in IDLE.
- `unload_start` input 1: request an unload; sampled only in IDLE.
- `busy` output 1: high in LOAD or UNLOAD.
- `done` output 1: one-cycle pulse when a load or unload completes.
- `range_err` output 1: sticky; set when a loaded coefficient is >= Q; cleared on the next accepted `load_start`.
- `s_data` input DATA_W: input coefficient.
- `s_valid` input 1: input coefficient is valid.
- `s_ready` output 1: block accepts `s_data`.
- `m_data` output DATA_W: output coefficient.
- `m_valid` output 1: `m_data` is valid.
- `m_ready` input 1: downstream accepts `m_data`.
- `ram_wea` output 1: port A write enable.
- `ram_addra` output ADDR_W: port A address.
- `ram_dia` output DATA_W: port A write data.
- `ram_doa` input DATA_W: port A read data, valid one cycle after the address is presented (synchronous read).

## Operation
- FSM has three states: IDLE, LOAD, UNLOAD.
  - IDLE -> LOAD on `load_start`.
  - IDLE -> UNLOAD on `unload_start`.
  - If both are high in the same cycle, LOAD wins and `unload_start` is dropped.
  - Starts seen outside IDLE are ignored (no queuing).
- LOAD:
  - `s_ready`=1.
  - `ram_wea = s_valid & s_ready`, `ram_addra` = load counter, `ram_dia = s_data`; all three are combinational.
  - On each handshake the counter increments and `range_err |= (s_data >= Q)`. Data is written unmodified.
  - After the handshake at counter N-1: next state is IDLE, `done` pulses in the first IDLE cycle, and `s_ready` is 0 in that cycle.
- UNLOAD:
  - `ram_wea`=0, `ram_addra` = read counter.
  - A 2-entry output FIFO is fed by RAM read data, with one read in flight tracked by a flag.
  - A read is issued in cycle t when `fifo_count + inflight - pop < 2` and the read counter is < N. `pop = m_valid & m_ready`.
  - Read data is pushed into the FIFO on the edge after the read cycle.
  - `m_valid` = FIFO non-empty; `m_data` = FIFO head, registered.
  - After the pop of coefficient N-1: next state is IDLE and `done` pulses.
  - Output order is address 0..N-1. No data is lost or duplicated under any `m_ready` pattern.
- Counters are ADDR_W+1 bits so that N is representable. Addresses never wrap within a single operation.
- `ram_addra` in IDLE is 0 and `ram_wea` is 0.

## Timing
- Reset values: `busy`=0, `done`=0, `range_err`=0, `s_ready`=0, `m_valid`=0, `m_data`=0, `ram_wea`=0, `ram_addra`=0, `ram_dia`=0. FIFO is empty, counters are 0, state is IDLE.
- Reset asserted mid-operation aborts immediately. Partially written RAM contents are left as-is. No `done` pulse is produced.
- Load:
  - `load_start` high at edge E0 -> `s_ready`=1 from the cycle after E0.
  - Throughput is 1 coefficient per cycle.
  - With `s_valid` held high, a full load takes N cycles, and `done` comes in cycle N+1 after E0.
- Unload:
  - `unload_start` at edge E0 -> read of address 0 in cycle 1 -> `m_valid`=1 in cycle 3.
  - Throughput is 1 per cycle with `m_ready` held high.
  - With `m_ready` held high, the last beat is in cycle N+2 and `done` is in cycle N+3.
  - Backpressure: with `m_ready`=0, at most 2 entries are buffered and no read is issued while the FIFO is full. Reads resume in the cycle `m_ready` pops.
  - `m_data` is stable while `m_valid & ~m_ready`.
- `busy` is high for exactly the cycles the FSM is in LOAD or UNLOAD.

## Test plan
- Reset then full load of values i*24 (i=0..511) with `s_valid` always high -> 512 writes, addr i data i*24, `done` exactly at cycle 513 after start, `range_err`=0.
- Load with `s_valid` toggling 1/0 and one coefficient 12289 at index 7 -> 512 writes in order, `range_err`=1 after index 7 and sticky; new `load_start` clears it.
- Unload after a preload with `m_ready`=1 -> `m_valid` first at cycle 3, 512 beats in order, `done` at cycle 515.
- Unload with random `m_ready` (30% high) -> all 512 values in order with no duplicates, `m_data` stable while stalled, at most 2 reads ahead of consumption.
- `load_start` and `unload_start` in the same cycle -> LOAD only; `unload_start` during LOAD is ignored.
- `rst` asserted at beat 200 of an unload -> all outputs return to reset values asynchronously, no `done`; a following unload restarts at address 0.
